// File: rtl/ray_multi_sphere_intersection.sv
// Nearest positive ray/sphere hit over a loadable sphere table, fixed point Q(WIDTH-FRAC).FRAC.
// Spheres are visited in order; each one runs dot products, the discriminant and a bit-serial square root.
module ray_multi_sphere_intersection #(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int NUM_SPHERES = 8,
    localparam int IDW        = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
    input  logic                   clk_render,
    input  logic                   rst,
    input  logic                   sphere_wr_en,
    output logic                   sphere_wr_ready,
    input  logic [IDW-1:0]         sphere_wr_addr,
    input  logic [2:0][WIDTH-1:0]  sphere_wr_loc,
    input  logic [WIDTH-1:0]       sphere_wr_radius_sq,
    input  logic                   sphere_wr_enable,
    output logic                   ray_axis_tready,
    input  logic                   ray_axis_tvalid,
    input  logic [2:0][WIDTH-1:0]  ray_axis_tdata,
    input  logic                   t_axis_tready,
    output logic                   t_axis_tvalid,
    output logic [WIDTH-1:0]       t_axis_tdata,
    output logic                   t_axis_hit,
    output logic [IDW-1:0]         t_axis_sphere_id
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + 2;
    localparam int BW = 2 * SW;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]    MAXPOS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MAXPOS_S = $signed({{(SW-WIDTH){1'b0}}, MAXPOS});

    typedef enum logic [2:0] {S_IDLE, S_DOT, S_DISC, S_SQRT, S_CMP, S_OUT} state_t;

    function automatic logic signed [SW-1:0] sx(input logic [WIDTH-1:0] v);
        return $signed({{(SW-WIDTH){v[WIDTH-1]}}, v});
    endfunction

    logic [NUM_SPHERES-1:0][2:0][WIDTH-1:0] tbl_loc;
    logic [NUM_SPHERES-1:0][WIDTH-1:0]      tbl_r2;
    logic [NUM_SPHERES-1:0]                 tbl_en;

    state_t                 state;
    logic [2:0][WIDTH-1:0]  dir;
    logic [IDW-1:0]         idx;
    logic signed [SW-1:0]   b, cc;
    logic                   miss;
    logic [PW-1:0]          rad;
    logic [WIDTH-1:0]       rem;
    logic [WIDTH-1:0]       root;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       best_t;
    logic                   best_hit;
    logic [IDW-1:0]         best_id;

    logic wr_addr_ok, wr_fire, last;

    generate
        if (NUM_SPHERES == (1 << IDW)) begin : g_full
            assign wr_addr_ok = 1'b1;
        end else begin : g_part
            assign wr_addr_ok = ({1'b0, sphere_wr_addr} < (IDW+1)'(NUM_SPHERES));
        end
    endgenerate

    assign wr_fire = sphere_wr_en && sphere_wr_ready && wr_addr_ok;
    assign last    = (idx == IDW'(NUM_SPHERES - 1));

    always_ff @(posedge clk_render) begin
        if (rst)
            tbl_en <= '0;
        else if (wr_fire)
            tbl_en[sphere_wr_addr] <= sphere_wr_enable;
    end

    always_ff @(posedge clk_render) begin
        if (wr_fire) begin
            tbl_loc[sphere_wr_addr] <= sphere_wr_loc;
            tbl_r2[sphere_wr_addr]  <= sphere_wr_radius_sq;
        end
    end

    // Per-sphere arithmetic; widths are generous so nothing wraps before saturation.
    logic signed [SW-1:0] sum_dc, sum_cc, b_n, cc_n;
    logic signed [BW-1:0] bx, bb, disc;
    logic                 disc_ovf;
    logic [PW-1:0]        rad_n;
    logic [WIDTH+1:0]     rem_sh, trial;
    logic signed [SW-1:0] t_full;
    logic [WIDTH-1:0]     t_sat;
    logic                 take;
    logic [WIDTH-1:0]     fin_t;
    logic                 fin_hit;
    logic [IDW-1:0]       fin_id;

    always_comb begin
        sum_dc = '0;
        sum_cc = '0;
        for (int k = 0; k < 3; k++) begin
            sum_dc = sum_dc + sx(dir[k]) * sx(tbl_loc[idx][k]);
            sum_cc = sum_cc + sx(tbl_loc[idx][k]) * sx(tbl_loc[idx][k]);
        end
        b_n  = sum_dc >>> FRAC;
        cc_n = (sum_cc >>> FRAC) - $signed({{(SW-WIDTH){1'b0}}, tbl_r2[idx]});

        bx       = $signed({{(BW-SW){b[SW-1]}}, b});
        bb       = bx * bx;
        disc     = (bb >>> FRAC) - $signed({{(BW-SW){cc[SW-1]}}, cc});
        disc_ovf = |disc[BW-2:PW-FRAC];
        rad_n    = disc_ovf ? '1 : {disc[PW-FRAC-1:0], {FRAC{1'b0}}};

        rem_sh = {rem, rad[PW-1 -: 2]};
        trial  = {root, 2'b01};

        t_full  = b - $signed({{(SW-WIDTH){1'b0}}, root});
        t_sat   = (t_full > MAXPOS_S) ? MAXPOS : t_full[WIDTH-1:0];
        // Strict less-than keeps the lower index on equal distances.
        take    = (state == S_CMP) && !miss && !t_full[SW-1] && (t_full != '0) && (t_sat < best_t);
        fin_t   = take ? t_sat : best_t;
        fin_hit = take | best_hit;
        fin_id  = take ? idx : best_id;
    end

    always_ff @(posedge clk_render) begin
        if (rst) begin
            state            <= S_IDLE;
            ray_axis_tready  <= 1'b0;
            sphere_wr_ready  <= 1'b0;
            t_axis_tvalid    <= 1'b0;
            t_axis_tdata     <= '0;
            t_axis_hit       <= 1'b0;
            t_axis_sphere_id <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ray_axis_tready <= 1'b1;
                    sphere_wr_ready <= 1'b1;
                    if (ray_axis_tvalid && ray_axis_tready) begin
                        dir             <= ray_axis_tdata;
                        idx             <= '0;
                        best_t          <= MAXPOS;
                        best_hit        <= 1'b0;
                        best_id         <= '0;
                        ray_axis_tready <= 1'b0;
                        sphere_wr_ready <= 1'b0;
                        state           <= S_DOT;
                    end
                end
                S_DOT: begin
                    if (tbl_en[idx]) begin
                        b     <= b_n;
                        cc    <= cc_n;
                        state <= S_DISC;
                    end else if (last) begin
                        t_axis_tvalid    <= 1'b1;
                        t_axis_tdata     <= fin_t;
                        t_axis_hit       <= fin_hit;
                        t_axis_sphere_id <= fin_hit ? fin_id : '0;
                        state            <= S_OUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DISC: begin
                    if (disc[BW-1]) begin
                        miss  <= 1'b1;
                        state <= S_CMP;
                    end else begin
                        miss  <= 1'b0;
                        rad   <= rad_n;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= S_SQRT;
                    end
                end
                S_SQRT: begin
                    rad <= rad << 2;
                    if (rem_sh >= trial) begin
                        rem  <= WIDTH'(rem_sh - trial);
                        root <= {root[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= rem_sh[WIDTH-1:0];
                        root <= {root[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == '0)
                        state <= S_CMP;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_CMP: begin
                    best_t   <= fin_t;
                    best_hit <= fin_hit;
                    best_id  <= fin_id;
                    if (last) begin
                        t_axis_tvalid    <= 1'b1;
                        t_axis_tdata     <= fin_t;
                        t_axis_hit       <= fin_hit;
                        t_axis_sphere_id <= fin_hit ? fin_id : '0;
                        state            <= S_OUT;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_DOT;
                    end
                end
                S_OUT: begin
                    if (t_axis_tready) begin
                        t_axis_tvalid   <= 1'b0;
                        ray_axis_tready <= 1'b1;
                        sphere_wr_ready <= 1'b1;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_multi_sphere_intersection.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops and compares them.
module tb_ray_multi_sphere_intersection;
    localparam logic [31:0] ONE    = 32'h0001_0000;
    localparam logic [31:0] MAXPOS = 32'h7FFF_FFFF;

    logic              clk_render = 1'b0;
    logic              rst = 1'b1;
    logic              sphere_wr_en = 1'b0;
    logic              sphere_wr_ready;
    logic [2:0]        sphere_wr_addr = '0;
    logic [2:0][31:0]  sphere_wr_loc = '0;
    logic [31:0]       sphere_wr_radius_sq = '0;
    logic              sphere_wr_enable = 1'b0;
    logic              ray_axis_tready;
    logic              ray_axis_tvalid = 1'b0;
    logic [2:0][31:0]  ray_axis_tdata = '0;
    logic              t_axis_tready = 1'b1;
    logic              t_axis_tvalid;
    logic [31:0]       t_axis_tdata;
    logic              t_axis_hit;
    logic [2:0]        t_axis_sphere_id;

    ray_multi_sphere_intersection #(.WIDTH(32), .FRAC(16), .NUM_SPHERES(8)) dut (
        .clk_render(clk_render), .rst(rst),
        .sphere_wr_en(sphere_wr_en), .sphere_wr_ready(sphere_wr_ready),
        .sphere_wr_addr(sphere_wr_addr), .sphere_wr_loc(sphere_wr_loc),
        .sphere_wr_radius_sq(sphere_wr_radius_sq), .sphere_wr_enable(sphere_wr_enable),
        .ray_axis_tready(ray_axis_tready), .ray_axis_tvalid(ray_axis_tvalid),
        .ray_axis_tdata(ray_axis_tdata),
        .t_axis_tready(t_axis_tready), .t_axis_tvalid(t_axis_tvalid),
        .t_axis_tdata(t_axis_tdata), .t_axis_hit(t_axis_hit),
        .t_axis_sphere_id(t_axis_sphere_id)
    );

    always #5 clk_render = ~clk_render;

    typedef struct {
        logic [31:0] t;
        logic        hit;
        logic [2:0]  id;
        int          lat;
        int          hs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk_render) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] t, input logic hit, input logic [2:0] id, input int lat);
        exp_t e;
        e.t = t; e.hit = hit; e.id = id; e.lat = lat; e.hs = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    // Monitor: first cycle of each tvalid pops an expectation; later cycles check holding.
    initial begin
        bit   seen;
        exp_t cur;
        seen = 0;
        cur  = mk(0, 0, 0, 0);
        forever begin
            @(negedge clk_render);
            if (rst) begin
                seen = 0;
            end else if (t_axis_tvalid) begin
                if (!seen) begin
                    seen = 1;
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: tdata 0x%0h with no pending ray", t_axis_tdata);
                    end else begin
                        cur = sb.pop_front();
                        chk("tdata", 64'(t_axis_tdata), 64'(cur.t));
                        chk("hit", 64'(t_axis_hit), 64'(cur.hit));
                        chk("sphere_id", 64'(t_axis_sphere_id), 64'(cur.id));
                        chk("latency", 64'(cyc - cur.hs + 1), 64'(cur.lat));
                    end
                end else begin
                    chk("hold_tdata", 64'(t_axis_tdata), 64'(cur.t));
                    chk("hold_hit", 64'(t_axis_hit), 64'(cur.hit));
                    chk("hold_id", 64'(t_axis_sphere_id), 64'(cur.id));
                    chk("hold_ray_ready", 64'(ray_axis_tready), 64'd0);
                    chk("hold_wr_ready", 64'(sphere_wr_ready), 64'd0);
                end
                if (t_axis_tready) seen = 0;
            end
        end
    end

    task automatic wr(input int addr, input logic [31:0] x, y, z, r2, input logic en);
        int k;
        k = 0;
        @(posedge clk_render); #1;
        sphere_wr_en = 1'b1; sphere_wr_addr = 3'(addr);
        sphere_wr_loc = {z, y, x}; sphere_wr_radius_sq = r2; sphere_wr_enable = en;
        @(negedge clk_render);
        while (!sphere_wr_ready && k < 200) begin @(negedge clk_render); k++; end
        if (k >= 200) begin n_checks++; $display("FAIL wr_timeout: sphere_wr_ready 0 after %0d cycles", k); end
        @(posedge clk_render); #1;
        sphere_wr_en = 1'b0;
    endtask

    // with_wr fires the pre-staged table write in the same cycle as the ray handshake.
    task automatic send_ray(input logic [31:0] dx, dy, dz, input bit push, input exp_t e, input bit with_wr);
        int k;
        k = 0;
        @(posedge clk_render); #1;
        ray_axis_tdata = {dz, dy, dx}; ray_axis_tvalid = 1'b1; sphere_wr_en = with_wr;
        @(negedge clk_render);
        while (!ray_axis_tready && k < 200) begin @(negedge clk_render); k++; end
        if (k >= 200) begin
            n_checks++;
            $display("FAIL ray_timeout: ray_axis_tready 0 after %0d cycles", k);
        end else if (push) begin
            e.hs = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk_render); #1;
        ray_axis_tvalid = 1'b0; sphere_wr_en = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((sb.size() != 0 || t_axis_tvalid) && k < 400) begin @(negedge clk_render); k++; end
        if (k >= 400) begin n_checks++; $display("FAIL result_timeout: pending %0d after %0d cycles", sb.size(), k); end
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk_render);
        chk("rst_tvalid", 64'(t_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(t_axis_tdata), 64'd0);
        chk("rst_hit", 64'(t_axis_hit), 64'd0);
        chk("rst_id", 64'(t_axis_sphere_id), 64'd0);
        chk("rst_ray_ready", 64'(ray_axis_tready), 64'd0);
        chk("rst_wr_ready", 64'(sphere_wr_ready), 64'd0);
        @(posedge clk_render); #1; rst = 1'b0;
        repeat (2) @(negedge clk_render);
        chk("idle_ray_ready", 64'(ray_axis_tready), 64'd1);
        chk("idle_wr_ready", 64'(sphere_wr_ready), 64'd1);

        // Single hit: sphere at z=5, r=1 -> t=4.
        wr(0, 0, 0, 5 * ONE, ONE, 1'b1);
        send_ray(0, 0, ONE, 1, mk(32'h0004_0000, 1, 0, 43), 0);
        @(negedge clk_render);
        chk("busy_ray_ready", 64'(ray_axis_tready), 64'd0);
        chk("busy_wr_ready", 64'(sphere_wr_ready), 64'd0);
        wait_done();

        // Nearest: add z=3 -> t=2 at id 1.
        wr(1, 0, 0, 3 * ONE, ONE, 1'b1);
        send_ray(0, 0, ONE, 1, mk(32'h0002_0000, 1, 1, 77), 0);
        wait_done();

        // Miss by direction: d along x, only entry 0 enabled.
        wr(1, 0, 0, 3 * ONE, ONE, 1'b0);
        send_ray(ONE, 0, 0, 1, mk(MAXPOS, 0, 0, 11), 0);
        wait_done();

        // Sphere behind the origin: t = -5 - 1 = -6, not a hit.
        wr(0, 0, 0, -(5 * ONE), ONE, 1'b1);
        send_ray(0, 0, ONE, 1, mk(MAXPOS, 0, 0, 43), 0);
        wait_done();

        // Tie at ids 2 and 5; entry 5 is written in the ray handshake cycle.
        wr(0, 0, 0, 0, 0, 1'b0);
        wr(2, 0, 0, 4 * ONE, ONE, 1'b1);
        sphere_wr_addr = 3'd5; sphere_wr_loc = {4 * ONE, 32'd0, 32'd0};
        sphere_wr_radius_sq = ONE; sphere_wr_enable = 1'b1;
        send_ray(0, 0, ONE, 1, mk(32'h0003_0000, 1, 2, 77), 1);
        wait_done();

        // Backpressure: hold tready low for 10 cycles after tvalid.
        @(posedge clk_render); #1; t_axis_tready = 1'b0;
        send_ray(0, 0, ONE, 1, mk(32'h0003_0000, 1, 2, 77), 0);
        k = 0;
        while (!t_axis_tvalid && k < 200) begin @(negedge clk_render); k++; end
        if (k >= 200) begin n_checks++; $display("FAIL bp_timeout: tvalid 0 after %0d cycles", k); end
        repeat (10) @(negedge clk_render);
        @(posedge clk_render); #1; t_axis_tready = 1'b1;
        @(posedge clk_render);
        @(negedge clk_render);
        chk("bp_release_tvalid", 64'(t_axis_tvalid), 64'd0);
        chk("bp_release_ray_ready", 64'(ray_axis_tready), 64'd1);
        chk("bp_release_wr_ready", 64'(sphere_wr_ready), 64'd1);

        // Reset during SQRT: result discarded, enables cleared.
        @(posedge clk_render); #1; rst = 1'b1;
        @(posedge clk_render); #1; rst = 1'b0;
        wr(0, 0, 0, 5 * ONE, ONE, 1'b1);
        send_ray(0, 0, ONE, 0, mk(0, 0, 0, 0), 0);
        repeat (10) @(posedge clk_render);
        #1; rst = 1'b1;
        @(posedge clk_render);
        @(negedge clk_render);
        chk("midrst_tvalid", 64'(t_axis_tvalid), 64'd0);
        @(posedge clk_render); #1; rst = 1'b0;
        repeat (60) @(negedge clk_render);
        chk("midrst_idle_ray_ready", 64'(ray_axis_tready), 64'd1);
        send_ray(0, 0, ONE, 1, mk(MAXPOS, 0, 0, 9), 0);
        wait_done();

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: %0d expected results never appeared", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
